// File: rtl/sensor_conditioner.sv
// Purpose: conditions raw vehicle-loop sensor pins into clean levels and latched service requests.
// Latency: sensor_db follows a stable raw change after 2 sync + DEBOUNCE_CYCLES cycles; request rises PRESENCE_CYCLES+1 cycles after sensor_db.
// Backpressure: none; a request is held until the consumer pulses clear for that channel.
//
// Ports:
//   clk          10 kHz system clock
//   reset        synchronous, active-high reset
//   sensor_raw   asynchronous raw sensor pins, 1 = vehicle present (bit 0 TH, 1 NN, 2 NS)
//   clear        one-cycle per-channel pulse: demand has been served
//   sensor_db    debounced sensor level
//   request      latched, qualified service demand
//   any_request  OR of request, registered and cycle-aligned with request
module sensor_conditioner #(
    parameter int NUM_SENSORS     = 3,
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int PRESENCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] sensor_raw,
    input  logic [NUM_SENSORS-1:0] clear,
    output logic [NUM_SENSORS-1:0] sensor_db,
    output logic [NUM_SENSORS-1:0] request,
    output logic                   any_request
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_PENDING = 2'd2
    } qual_state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PRESENCE_CYCLES - 1);

    // Two-flop synchronizer; sync_s is the first metastability-safe copy.
    logic [NUM_SENSORS-1:0] sync_meta;
    logic [NUM_SENSORS-1:0] sync_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= sensor_raw;
            sync_s    <= sync_meta;
        end
    end

    // Next-state request vector, used to register any_request in step with request.
    logic [NUM_SENSORS-1:0] request_nxt;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch

        // ---------------- debounce ----------------
        logic [CNT_W-1:0] dcnt;
        logic             db_q;

        // dcnt counts consecutive cycles the synchronized level disagrees with
        // the accepted level; any agreement restarts the count.
        always_ff @(posedge clk) begin
            if (reset) begin
                dcnt <= '0;
                db_q <= 1'b0;
            end else if (sync_s[i] == db_q) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                db_q <= sync_s[i];
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end

        assign sensor_db[i] = db_q;

        // ---------------- presence qualifier ----------------
        qual_state_t      state_q, state_d;
        logic [CNT_W-1:0] pcnt_q, pcnt_d;
        logic             req_q, req_d;

        always_comb begin
            state_d = state_q;
            pcnt_d  = pcnt_q;
            req_d   = req_q;
            case (state_q)
                ST_IDLE: begin
                    pcnt_d = '0;
                    req_d  = 1'b0;
                    if (db_q) begin
                        state_d = ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    req_d = 1'b0;
                    if (!db_q) begin
                        state_d = ST_IDLE;
                        pcnt_d  = '0;
                    end else if (clear[i]) begin
                        // A clear arriving on the completion cycle also lands
                        // here, so it suppresses that request.
                        pcnt_d = '0;
                    end else if (pcnt_q == PR_LAST) begin
                        state_d = ST_PENDING;
                        req_d   = 1'b1;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                ST_PENDING: begin
                    // Held regardless of sensor level: the vehicle may have
                    // moved off the loop but is still owed service.
                    req_d = 1'b1;
                    if (clear[i]) begin
                        req_d   = 1'b0;
                        pcnt_d  = '0;
                        state_d = db_q ? ST_QUALIFY : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                    req_d   = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                pcnt_q  <= '0;
                req_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                pcnt_q  <= pcnt_d;
                req_q   <= req_d;
            end
        end

        assign request[i]     = req_q;
        assign request_nxt[i] = req_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            any_request <= 1'b0;
        end else begin
            any_request <= |request_nxt;
        end
    end

endmodule
